// File: rtl/singles_merger.sv
// Round-robin merger of per-block single-event streams into one output word stream,
// with time-tag words inserted after each period_done once no block is stalling.
module singles_merger #(
  parameter int unsigned NBLOCKS   = 4,
  parameter int unsigned DATA_BITS = 128,
  parameter int unsigned TT_BITS   = 48
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NBLOCKS-1:0]           in_valid,
  output logic [NBLOCKS-1:0]           in_ready,
  input  logic [NBLOCKS*DATA_BITS-1:0] in_data,
  input  logic [NBLOCKS-1:0]           in_stall,
  input  logic                         period_done,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_BITS-1:0]         out_data,
  output logic                         tt_overrun,
  output logic [31:0]                  n_merged
);

  localparam int unsigned PtrW = (NBLOCKS > 1) ? $clog2(NBLOCKS) : 1;
  localparam int unsigned PadW = DATA_BITS - 6 - TT_BITS;
  localparam logic [PtrW-1:0]    PtrRst = PtrW'(NBLOCKS - 1);
  localparam logic [TT_BITS-1:0] TtOne  = TT_BITS'(1);

  logic                 out_valid_q, out_valid_d;
  logic [DATA_BITS-1:0] out_data_q, out_data_d;
  logic [PtrW-1:0]      ptr_q, ptr_d;
  logic [TT_BITS-1:0]   tt_count_q, tt_count_d;
  logic [TT_BITS-1:0]   tag_value_q, tag_value_d;
  logic                 tt_pending_q, tt_pending_d;
  logic                 tt_overrun_q, tt_overrun_d;
  logic [31:0]          n_merged_q, n_merged_d;

  logic            free;
  logic            tag_load;
  logic            single_load;
  logic            found;
  logic [PtrW-1:0] gnt_idx;
  logic [PtrW-1:0] cand;

  // First valid block strictly after the last granted one, wrapping modulo NBLOCKS.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 1; i <= int'(NBLOCKS); i++) begin
      cand = PtrW'((int'(ptr_q) + i) % int'(NBLOCKS));
      if (!found && in_valid[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign free        = ~out_valid_q | out_ready;
  assign tag_load    = free & tt_pending_q & ~(|in_stall);
  assign single_load = free & ~tag_load & found;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    ptr_d        = ptr_q;
    tt_count_d   = tt_count_q;
    tag_value_d  = tag_value_q;
    tt_pending_d = tt_pending_q;
    tt_overrun_d = tt_overrun_q;
    n_merged_d   = n_merged_q;
    in_ready     = '0;

    if (tag_load) begin
      out_valid_d = 1'b1;
      out_data_d  = {5'b11111, 1'b0, {PadW{1'b0}}, tag_value_q};
    end else if (single_load) begin
      out_valid_d       = 1'b1;
      out_data_d        = in_data[DATA_BITS*gnt_idx +: DATA_BITS];
      ptr_d             = gnt_idx;
      n_merged_d        = n_merged_q + 32'd1;
      in_ready[gnt_idx] = ~rst;
    end else if (free) begin
      out_valid_d = 1'b0;
    end

    // A pulse coinciding with a tag load re-arms the tag without counting as an overrun.
    if (period_done) begin
      tt_count_d   = tt_count_q + TtOne;
      tag_value_d  = tt_count_q + TtOne;
      tt_pending_d = 1'b1;
      if (tt_pending_q && !tag_load) begin
        tt_overrun_d = 1'b1;
      end
    end else if (tag_load) begin
      tt_pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      ptr_q        <= PtrRst;
      tt_count_q   <= '0;
      tag_value_q  <= '0;
      tt_pending_q <= 1'b0;
      tt_overrun_q <= 1'b0;
      n_merged_q   <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      ptr_q        <= ptr_d;
      tt_count_q   <= tt_count_d;
      tag_value_q  <= tag_value_d;
      tt_pending_q <= tt_pending_d;
      tt_overrun_q <= tt_overrun_d;
      n_merged_q   <= n_merged_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign tt_overrun = tt_overrun_q;
  assign n_merged   = n_merged_q;

endmodule
